// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer scheduler and the SPI master.
// State encoding, default word width and the system clock frequency.
package spi_pkg;

  localparam int WIDTH_DEF = 13;
  localparam int CLKFREQ   = 27000000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } xfer_state_t;

endpackage

// File: rtl/spi_xfer_sched_rr_arbiter.sv
// Rotating-priority pick: the first requester after ptr wins, cyclically.
// Purely combinational; the caller registers the result.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  int          j;
  logic [PW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j  = (int'(ptr) + i) % NREQ;
      jj = PW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Shares one SPI master between NREQ requesters: round-robin grant,
// start pulse, wait for load (or timeout), return data, idle gap.
module spi_xfer_sched
  import spi_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_dat,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      rsp_dat,
  output logic                  err,
  output logic                  busy,
  output logic                  spi_start,
  output logic [WIDTH-1:0]      spi_mtx_dat,
  input  logic                  spi_load,
  input  logic [WIDTH-1:0]      spi_srx_dat
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  xfer_state_t   state_q;
  xfer_state_t   state_d;
  logic [PW-1:0] ptr_q;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_inc;
  logic [GW-1:0] gap_q;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;
  logic            tmo_hit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign tmo_inc = tmo_q + 1'b1;
  assign tmo_hit = (tmo_inc == TO_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (arb_any) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (spi_load || tmo_hit) state_d = S_DONE;
      S_DONE:  state_d = S_GAP;
      S_GAP:   if (gap_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the transition being taken this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= PW'(NREQ - 1);
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      spi_start   <= 1'b0;
      rsp_dat     <= '0;
      spi_mtx_dat <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != S_IDLE);
      spi_start <= (state_q == S_IDLE) && arb_any;
      done      <= '0;
      err       <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            gnt         <= arb_gnt;
            ptr_q       <= arb_idx;
            spi_mtx_dat <= req_dat[arb_idx*WIDTH +: WIDTH];
          end
        end
        S_START: tmo_q <= '0;
        S_WAIT: begin
          if (spi_load) begin
            rsp_dat <= spi_srx_dat;
            done    <= gnt;
          end else if (tmo_hit) begin
            rsp_dat <= '0;
            done    <= gnt;
            err     <= 1'b1;
          end else begin
            tmo_q <= tmo_inc;
          end
        end
        S_DONE: begin
          gnt   <= '0;
          gap_q <= GW'(GAP_CYCLES - 1);
        end
        S_GAP: begin
          if (gap_q != '0) gap_q <= gap_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched with an SPI stub and a
// scoreboard monitor checking every start and done event.
`timescale 1ns/1ps
module tb_spi_xfer_sched;

  localparam int W   = 13;
  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TMO = 100;
  localparam int DW  = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [DW-1:0] req_dat = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic [W-1:0]  rsp_dat;
  logic          err;
  logic          busy;
  logic          spi_start;
  logic [W-1:0]  spi_mtx_dat;
  logic          spi_load;
  logic [W-1:0]  spi_srx_dat;

  logic         stub_load = 1'b0;
  logic         stray_load = 1'b0;
  logic [W-1:0] stub_dat = '0;
  logic [W-1:0] stray_dat = '0;

  assign spi_load    = stub_load | stray_load;
  assign spi_srx_dat = stray_load ? stray_dat : stub_dat;

  spi_xfer_sched #(
    .WIDTH(W), .NREQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_dat     (req_dat),
    .gnt         (gnt),
    .done        (done),
    .rsp_dat     (rsp_dat),
    .err         (err),
    .busy        (busy),
    .spi_start   (spi_start),
    .spi_mtx_dat (spi_mtx_dat),
    .spi_load    (spi_load),
    .spi_srx_dat (spi_srx_dat)
  );

  always #18 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic [W-1:0] mtx;
    int           gap;
  } start_t;

  typedef struct {
    logic [N-1:0] d;
    logic [W-1:0] rsp;
    logic         e;
    logic [W-1:0] mtx;
    int           lat;
  } done_t;

  typedef struct {
    int           dly;
    logic [W-1:0] dat;
    bit           silent;
  } stub_t;

  start_t start_q[$];
  done_t  done_q[$];
  stub_t  stub_q[$];
  start_t sit;
  done_t  dit;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm, input string why);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s @cyc %0d", nm, why, cyc);
  endtask

  // kind: 0 normal, 1 timeout, 2 aborted by reset
  task automatic plan(input int i, input logic [W-1:0] mtx,
                      input int gap, input int dly,
                      input logic [W-1:0] rsp, input int kind);
    start_q.push_back('{g: N'(1 << i), mtx: mtx, gap: gap});
    stub_q.push_back('{dly: dly, dat: rsp, silent: (kind != 0)});
    if (kind == 0)
      done_q.push_back('{d: N'(1 << i), rsp: rsp, e: 1'b0,
                         mtx: mtx, lat: dly + 1});
    else if (kind == 1)
      done_q.push_back('{d: N'(1 << i), rsp: '0, e: 1'b1,
                         mtx: mtx, lat: TMO});
  endtask

  task automatic set_dat(input int i, input logic [W-1:0] v);
    req_dat[i*W +: W] = v;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int maxc, input string nm);
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (done != '0) return;
    end
    fail(nm, "no done pulse");
  endtask

  // SPI stub: answers each start as scripted.
  initial begin : stub
    stub_t s;
    forever begin
      @(negedge clk);
      if (rst_n && spi_start && stub_q.size() > 0) begin
        s = stub_q.pop_front();
        if (!s.silent) begin
          repeat (s.dly) @(negedge clk);
          stub_dat  = s.dat;
          stub_load = 1'b1;
          @(negedge clk);
          stub_load = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    if (rst_n && spi_start) begin
      if (start_q.size() == 0) begin
        fail("start_unexpected", "spi_start with nothing planned");
      end else begin
        sit = start_q.pop_front();
        check("start_gnt", 32'(gnt), 32'(sit.g));
        check("start_mtx", 32'(spi_mtx_dat), 32'(sit.mtx));
        if (sit.gap >= 0)
          check("start_gap", cyc - done_cyc, sit.gap);
      end
      start_cyc = cyc;
    end
    if (rst_n && done != '0) begin
      if (done_q.size() == 0) begin
        fail("done_unexpected", "done with nothing planned");
      end else begin
        dit = done_q.pop_front();
        check("done_vec", 32'(done), 32'(dit.d));
        check("done_rsp", 32'(rsp_dat), 32'(dit.rsp));
        check("done_err", 32'(err), 32'(dit.e));
        check("done_mtx", 32'(spi_mtx_dat), 32'(dit.mtx));
        check("done_lat", cyc - start_cyc, dit.lat);
      end
      done_cyc = cyc;
    end
  end

  initial begin : watchdog
    #(36 * 20000);
    $display("FAIL watchdog: run did not complete @cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit got;
    got = 1'b0;

    // reset state
    cycles(3);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(spi_start), 0);
    check("rst_rsp", 32'(rsp_dat), 0);
    check("rst_mtx", 32'(spi_mtx_dat), 0);
    rst_n = 1'b1;
    cycles(2);
    check("idle_busy", 32'(busy), 0);

    // single request
    set_dat(0, 13'h1DAD);
    plan(0, 13'h1DAD, -1, 50, 13'h0CED, 0);
    req = 4'b0001;
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_start", 32'(spi_start), 1);
    check("t1_busy", 32'(busy), 1);
    @(negedge clk);
    check("t1_start_once", 32'(spi_start), 0);
    wait_done(80, "t1_done");
    req = '0;
    cycles(GAP + 4);
    check("t1_idle", 32'(busy), 0);
    check("t1_gnt_low", 32'(gnt), 0);
    check("t1_rsp_held", 32'(rsp_dat), 32'h0CED);

    // contention, fresh pointer
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    for (int i = 0; i < N; i++) set_dat(i, W'(13'h0A0 + i));
    plan(0, 13'h0A0, -1, 5, 13'h0101, 0);
    plan(1, 13'h0A1, GAP + 2, 5, 13'h0102, 0);
    plan(2, 13'h0A2, GAP + 2, 5, 13'h0103, 0);
    plan(3, 13'h0A3, GAP + 2, 5, 13'h0104, 0);
    plan(0, 13'h0A0, GAP + 2, 5, 13'h0105, 0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_done(GAP + 40, "t2_done");
    req = '0;
    cycles(GAP + 4);
    check("t2_idle", 32'(busy), 0);

    // timeout then a normal transfer
    set_dat(2, 13'h1555);
    plan(2, 13'h1555, -1, 0, 13'h0, 1);
    req = 4'b0100;
    wait_done(TMO + 10, "t3_tmo_done");
    req = '0;
    set_dat(3, 13'h0333);
    plan(3, 13'h0333, GAP + 2, 10, 13'h1234, 0);
    req = 4'b1000;
    wait_done(GAP + 40, "t3_done");
    req = '0;
    cycles(GAP + 4);

    // stray loads in IDLE, START and GAP
    stray_dat  = 13'h0BAD;
    stray_load = 1'b1;
    @(negedge clk);
    stray_load = 1'b0;
    cycles(2);
    check("t4_idle_busy", 32'(busy), 0);
    check("t4_idle_rsp", 32'(rsp_dat), 32'h1234);
    set_dat(0, 13'h0ABC);
    plan(0, 13'h0ABC, -1, 20, 13'h0777, 0);
    req = 4'b0001;
    @(negedge clk);
    stray_load = 1'b1;
    @(negedge clk);
    stray_load = 1'b0;
    check("t4_wait_busy", 32'(busy), 1);
    wait_done(40, "t4_done");
    req = '0;
    @(negedge clk);
    stray_load = 1'b1;
    @(negedge clk);
    stray_load = 1'b0;
    cycles(GAP + 2);
    check("t4_gap_busy", 32'(busy), 0);
    check("t4_gap_rsp", 32'(rsp_dat), 32'h0777);

    // reset in WAIT
    set_dat(3, 13'h0F00);
    plan(3, 13'h0F00, -1, 0, 13'h0, 2);
    req = 4'b1000;
    cycles(10);
    rst_n = 1'b0;
    #1;
    check("t5_gnt", 32'(gnt), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_start", 32'(spi_start), 0);
    check("t5_rsp", 32'(rsp_dat), 0);
    check("t5_mtx", 32'(spi_mtx_dat), 0);
    req = '0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    set_dat(1, 13'h0111);
    set_dat(2, 13'h0222);
    plan(1, 13'h0111, -1, 7, 13'h0555, 0);
    plan(2, 13'h0222, GAP + 2, 3, 13'h0666, 0);
    req = 4'b0110;
    wait_done(30, "t5_done1");
    req = 4'b0100;
    wait_done(GAP + 30, "t5_done2");
    req = '0;
    cycles(GAP + 4);

    // data stability, then back-to-back single requester
    set_dat(0, 13'h1ABC);
    plan(0, 13'h1ABC, -1, 12, 13'h0ACE, 0);
    plan(0, 13'h0F0F, GAP + 2, 4, 13'h0321, 0);
    req = 4'b0001;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (done != '0) got = 1'b1;
      check("t6_mtx_hold", 32'(spi_mtx_dat), 32'h1ABC);
      if (!got) req_dat = DW'({$urandom(), $urandom()});
    end
    if (!got) fail("t6_done", "no done pulse");
    set_dat(0, 13'h0F0F);
    wait_done(GAP + 30, "t6_done2");
    req = '0;
    cycles(GAP + 4);

    check("sb_start_empty", start_q.size(), 0);
    check("sb_done_empty", done_q.size(), 0);
    check("sb_stub_empty", stub_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sched.md
# spi_xfer_sched

Transfer scheduler that shares the single `spi` master between up to `NREQ` requesters. It arbitrates round-robin, latches the winner's transmit word, issues a one-cycle start to the SPI master and waits for its `load` completion pulse. It then returns the received word to the winner and enforces an idle gap before the next transfer. It sits between `top`-level producers (counters, switch samplers, display logic) and the `spi` instance, and replaces the direct `mtx_dat`/`load` wiring.

## Interface
- `WIDTH`, 13: SPI word width in bits.
- `NREQ`, 4: number of requesters; must be 2–8.
- `GAP_CYCLES`, 16: idle `clk` cycles between transfers; must be ≥1.
- `TIMEOUT`, 65535: maximum `clk` cycles spent waiting for `spi_load` before a transfer is aborted.

Ports:
- `clk` in 1: system clock, 27 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `NREQ`: per-requester level request; the requester holds it until its `done` bit fires.
- `req_dat` in `NREQ*WIDTH`: transmit words; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `gnt` out `NREQ`: one-hot grant, high for the whole transfer.
- `done` out `NREQ`: one-cycle completion pulse to the granted requester.
- `rsp_dat` out `WIDTH`: received word, valid in the `done` cycle and held until the next `done`.
- `err` out 1: one-cycle pulse that accompanies `done` on a timeout.
- `busy` out 1: high in every state except IDLE.
- `spi_start` out 1: one-cycle start pulse to the SPI master.
- `spi_mtx_dat` out `WIDTH`: latched transmit word, stable from START until the end of DONE.
- `spi_load` in 1: SPI completion pulse, one `clk` cycle wide and synchronous to `clk`.
- `spi_srx_dat` in `WIDTH`: word received by the SPI master, valid while `spi_load` is high.

## Operation
- Reset values:
  - state IDLE.
  - `gnt`, `done`, `err`, `busy`, `spi_start` = 0.
  - `rsp_dat`, `spi_mtx_dat` = 0.
  - round-robin pointer = `NREQ-1`, so requester 0 wins the first arbitration.
  - gap and timeout counters = 0.
- FSM states: IDLE → START → WAIT → DONE → GAP → IDLE.
  - IDLE: if any `req` bit is high, grant the first requesting index found after the pointer, cyclically. Register the one-hot `gnt`, latch that requester's `req_dat` slice into `spi_mtx_dat`, set the pointer to the winner, and go to START.
  - START: `spi_start` = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: on `spi_load`, capture `spi_srx_dat` into `rsp_dat` and go to DONE. Otherwise increment the timeout counter; when it reaches `TIMEOUT-1`, set `rsp_dat` = 0, set the error flag and go to DONE.
  - DONE: `done[winner]` = 1 and `err` = error flag for this cycle; clear the flag; load the gap counter with `GAP_CYCLES-1`; go to GAP.
  - GAP: `gnt` = 0; decrement the counter; go to IDLE when it reaches 0.
- `spi_load` is ignored outside WAIT, including a pulse in the START cycle. Stray pulses in IDLE/GAP have no effect.
- `req_dat` is sampled only at grant. Later changes do not affect the transfer in progress.
- Dropping `req` after grant does not abort the transfer. `done` still fires, and the requester must ignore it.
- A requester that still holds `req` after its `done` re-enters arbitration with the lowest priority.
- Requesters with no `req` are skipped. With a single active requester, it is granted back-to-back, separated only by the gap.
- `rst_n` asserted mid-transfer:
  - All outputs return to reset values immediately; `spi_start` is never re-issued.
  - The SPI master is reset from the same source.

## Timing
- `req` is seen at edge n: `gnt` and `spi_mtx_dat` are valid after edge n, and `spi_start` is high in cycle n+1.
- `spi_load` is high in cycle k: `done`, `rsp_dat` and `err` are valid in cycle k+1, and `gnt` falls after edge k+2.
- The minimum spacing between two `spi_start` pulses is 4 + `GAP_CYCLES` plus the SPI transfer time.
- A timeout fires exactly `TIMEOUT` cycles after the START cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `spi_pkg`:
  - state encoding constants (IDLE, START, WAIT, DONE, GAP; 3 bits).
  - default `WIDTH` = 13.
  - `CLKFREQ` = 27000000, shared with `spi`.
- Sub-module `rr_arbiter` (parameter `NREQ`): combinational rotating-priority pick from `req` and the pointer, producing a one-hot grant and its index. The FSM, counters and data latches stay in `spi_xfer_sched`.

## Test plan
- Single request: `req` = 0001, `req_dat[0]` = 0x1DAD, stub answers 0x0CED after 50 cycles → one `spi_start`, `spi_mtx_dat` = 0x1DAD, `done` = 0001, `rsp_dat` = 0x0CED, `err` = 0.
- Contention: `req` = 1111 held continuously → grants occur in order 0, 1, 2, 3, 0, each with exactly one `done`, separated by ≥`GAP_CYCLES` idle cycles.
- Timeout: `TIMEOUT` = 100, stub never pulses `spi_load` → `done` and `err` fire 100 cycles after START, `rsp_dat` = 0, then a normal transfer follows.
- Stray loads: `spi_load` pulsed in IDLE, GAP and the START cycle → no state change; the transfer completes only on the pulse received in WAIT.
- Reset mid-WAIT: `rst_n` low for 3 cycles during WAIT → all outputs 0 at once, pointer back to `NREQ-1`, the next `req` = 0110 grants requester 1.
- Data stability: `req_dat` changed every cycle after grant → `spi_mtx_dat` holds the value captured at grant through DONE.
